// File: rtl/bist_lfsr_engine_pkg.sv
// Shared types for the BIST pattern engine: burst modes and controller states.
package bist_pkg;

  typedef enum logic [1:0] {
    MODE_GALOIS = 2'b00,
    MODE_FIB    = 2'b01,
    MODE_MISR   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/bist_lfsr_engine_lfsr_step.sv
// One combinational step of the LFSR/MISR register: Galois, Fibonacci or MISR.
// Kept free of state so a standalone signature compactor can reuse it.
module lfsr_step
  import bist_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] q,
  input  logic [N-1:0] poly,
  input  logic [N-1:0] din,
  input  mode_t        mode,
  output logic [N-1:0] next
);

  logic [N-1:0] galois;

  // The top tap bit is implied by the shift-in of q[0]; poly[N-1] plays no part.
  assign galois[N-1] = q[0];

  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_galois
      assign galois[gi] = (q[0] & poly[gi]) ^ q[gi+1];
    end
  endgenerate

  always_comb begin
    next = q;
    case (mode)
      MODE_GALOIS: next = galois;
      MODE_FIB:    next = {^(q & poly), q[N-1:1]};
      MODE_MISR:   next = galois ^ din;
      default:     next = q;
    endcase
  end

endmodule

// File: rtl/bist_lfsr_engine.sv
// BIST pattern engine: bounded burst of TPG patterns or MISR compaction steps,
// with a start/done handshake and a per-pattern valid/ready stall.
module bist_lfsr_engine
  import bist_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     poly,
  input  logic [N-1:0]     seed,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [N-1:0]     din,
  input  logic             pat_ready,
  output logic             pat_valid,
  output logic [N-1:0]     d_out,
  output logic [CNT_W-1:0] pat_idx,
  output logic             busy,
  output logic             done
);

  state_t           state_reg, state_next;
  mode_t            mode_reg, mode_next;
  mode_t            mode_in;
  logic [N-1:0]     poly_reg, poly_next;
  logic [N-1:0]     d_reg, d_next;
  logic [N-1:0]     step_next;
  logic [CNT_W-1:0] num_reg, num_next;
  logic [CNT_W-1:0] idx_reg, idx_next;
  logic             handshake;
  logic             seed_zero_tpg;

  assign mode_in       = mode_t'(mode);
  assign handshake     = (state_reg == S_RUN) && pat_ready;
  // An all-zero TPG register would lock up; MISR keeps a zero seed as-is.
  assign seed_zero_tpg = (seed == '0) && (mode_in == MODE_GALOIS || mode_in == MODE_FIB);

  lfsr_step #(.N(N)) u_step (
    .q    (d_reg),
    .poly (poly_reg),
    .din  (din),
    .mode (mode_reg),
    .next (step_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      mode_reg  <= MODE_GALOIS;
      poly_reg  <= '0;
      num_reg   <= '0;
      d_reg     <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      poly_reg  <= poly_next;
      num_reg   <= num_next;
      d_reg     <= d_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    poly_next  = poly_reg;
    num_next   = num_reg;
    d_next     = d_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          mode_next  = mode_in;
          poly_next  = poly;
          num_next   = num_patterns;
          d_next     = seed_zero_tpg ? {{(N-1){1'b0}}, 1'b1} : seed;
          idx_next   = '0;
          state_next = (num_patterns == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (handshake) begin
          d_next = step_next;
          // The index saturates at the last pattern; the final step still advances d_out.
          if (idx_reg == num_reg - 1'b1) begin
            state_next = S_DONE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign pat_valid = (state_reg == S_RUN);
  assign busy      = (state_reg == S_RUN);
  assign done      = (state_reg == S_DONE);
  assign d_out     = d_reg;
  assign pat_idx   = idx_reg;

endmodule
